mem_wrap_mp: RTL and testbench

Parametrised successor to the single-write / dual-read image RAM wrapper used around dog_top and its benches. It provides one write port, NRD independent read ports with configurable read latency and per-port valid, and a selectable read-during-write policy. It also has a built-in fill engine that initialises the whole array to a constant value without a bench-side load loop. The block is used as frame/line buffer storage in the image pipelines and as the memory model in their testbenches.

---
 rtl/mem_wrap_mp.sv | 144 ++++++++++++++
 tb/tb_mem_wrap_mp.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wrap_mp.sv
// Single-write, multi-read RAM wrapper with a configurable read pipeline, a selectable
// read-during-write policy and a built-in whole-array fill engine.
module mem_wrap_mp #(
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 16,
    parameter int unsigned NRD      = 2,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned WR_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic [DW-1:0]     init_val,
    output logic              busy,
    input  logic              wea,
    input  logic [AW-1:0]     addra,
    input  logic [DW-1:0]     dina,
    output logic              wr_drop,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_valid
);

    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic {StIdle, StFill} state_e;

    logic [DW-1:0] mem [Depth];

    state_e      state_q, state_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [DW-1:0] fill_val_q, fill_val_d;
    logic        wr_drop_q, wr_drop_d;

    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    logic [AW-1:0] raddr [NRD];
    logic [DW-1:0] rword [NRD];

    logic [NRD-1:0]    vld_q [RD_LAT];
    logic [NRD-1:0]    vld_d [RD_LAT];
    logic [NRD*DW-1:0] dat_q [RD_LAT];
    logic [NRD*DW-1:0] dat_d [RD_LAT];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            fill_val_q <= '0;
            wr_drop_q  <= 1'b0;
            for (int s = 0; s < RD_LAT; s++) begin
                vld_q[s] <= '0;
                dat_q[s] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_val_q <= fill_val_d;
            wr_drop_q  <= wr_drop_d;
            for (int s = 0; s < RD_LAT; s++) begin
                vld_q[s] <= vld_d[s];
                dat_q[s] <= dat_d[s];
            end
        end
    end

    // Next-state logic; the extra counter bit flags the end of the sweep
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_val_d = fill_val_q;
        unique case (state_q)
            StIdle: begin
                if (init) begin
                    state_d    = StFill;
                    cnt_d      = '0;
                    fill_val_d = init_val;
                end
            end
            StFill: begin
                cnt_d = cnt_q + (AW + 1)'(1);
                if (cnt_d[AW]) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Output and write-port logic
    always_comb begin
        busy      = (state_q == StFill);
        wr_drop   = wr_drop_q;
        wr_drop_d = (state_q == StFill) && wea;
        we        = (state_q == StFill) || wea;
        waddr     = (state_q == StFill) ? cnt_q[AW-1:0] : addra;
        wdata     = (state_q == StFill) ? fill_val_q : dina;
        rd_valid  = vld_q[RD_LAT-1];
        rd_data   = dat_q[RD_LAT-1];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            raddr[p] = rd_addr[p*AW +: AW];
            if ((WR_FIRST != 0) && we && (waddr == raddr[p])) begin
                rword[p] = wdata;
            end else begin
                rword[p] = mem[raddr[p]];
            end
        end
    end

    // Data in each stage only advances alongside a valid, so the output holds between reads
    always_comb begin
        for (int s = 0; s < RD_LAT; s++) begin
            vld_d[s] = vld_q[s];
            dat_d[s] = dat_q[s];
        end
        vld_d[0] = rd_en;
        for (int p = 0; p < NRD; p++) begin
            if (rd_en[p]) begin
                dat_d[0][p*DW +: DW] = rword[p];
            end
        end
        for (int s = 1; s < RD_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            for (int p = 0; p < NRD; p++) begin
                if (vld_q[s-1][p]) begin
                    dat_d[s][p*DW +: DW] = dat_q[s-1][p*DW +: DW];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wrap_mp.sv
// Scoreboard bench: two small instances (read-first and write-first) share stimulus, a third
// instance runs the full-size legacy configuration.
module tb_mem_wrap_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        init;
    logic [7:0]  init_val;
    logic        wea;
    logic [3:0]  addra;
    logic [7:0]  dina;
    logic [2:0]  rd_en;
    logic [11:0] rd_addr;

    logic        busy_a, busy_b, wr_drop_a, wr_drop_b;
    logic [2:0]  rdv_a, rdv_b;
    logic [23:0] rdd_a, rdd_b;

    logic        wea_c;
    logic [15:0] addra_c;
    logic [7:0]  dina_c;
    logic [1:0]  rd_en_c;
    logic [31:0] rd_addr_c;
    logic        busy_c, wr_drop_c;
    logic [1:0]  rdv_c;
    logic [15:0] rdd_c;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         dut;
        int         port;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_wrap_mp #(.DW(8), .AW(4), .NRD(3), .RD_LAT(2), .WR_FIRST(0)) u_a (
        .clk(clk), .rst(rst), .init(init), .init_val(init_val), .busy(busy_a),
        .wea(wea), .addra(addra), .dina(dina), .wr_drop(wr_drop_a),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd_a), .rd_valid(rdv_a)
    );

    mem_wrap_mp #(.DW(8), .AW(4), .NRD(3), .RD_LAT(2), .WR_FIRST(1)) u_b (
        .clk(clk), .rst(rst), .init(init), .init_val(init_val), .busy(busy_b),
        .wea(wea), .addra(addra), .dina(dina), .wr_drop(wr_drop_b),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd_b), .rd_valid(rdv_b)
    );

    mem_wrap_mp #(.DW(8), .AW(16), .NRD(2), .RD_LAT(1), .WR_FIRST(0)) u_c (
        .clk(clk), .rst(rst), .init(1'b0), .init_val(8'h00), .busy(busy_c),
        .wea(wea_c), .addra(addra_c), .dina(dina_c), .wr_drop(wr_drop_c),
        .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rdd_c), .rd_valid(rdv_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int p, input logic [7:0] v);
        exp_t e;
        e.dut  = d;
        e.port = p;
        e.data = v;
        e.due  = cyc + ((d == 2) ? 1 : 2);
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int x);
        logic [15:0] w;
        w = 16'(x);
        return w[7:0] ^ w[15:8] ^ 8'h5A;
    endfunction

    // Monitor: every presented valid must match a scoreboard entry due on this exact cycle
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            for (int p = 0; p < 3; p++) begin
                logic       v;
                logic [7:0] dt;
                int         idx;
                if (d == 2 && p == 2) continue;
                case (d)
                    0:       begin v = rdv_a[p]; dt = rdd_a[p*8 +: 8]; end
                    1:       begin v = rdv_b[p]; dt = rdd_b[p*8 +: 8]; end
                    default: begin v = rdv_c[p]; dt = rdd_c[p*8 +: 8]; end
                endcase
                if (v === 1'b1) begin
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (idx < 0 && sb[i].dut == d && sb[i].port == p && sb[i].due == cyc)
                            idx = i;
                    end
                    n_checks++;
                    if (idx < 0) begin
                        n_fail++;
                        $display("FAIL unexpected_valid dut%0d port%0d: got data %0h, required no valid (cycle %0d)",
                                 d, p, dt, cyc);
                    end else begin
                        if (dt !== sb[idx].data) begin
                            n_fail++;
                            $display("FAIL read_data dut%0d port%0d: got %0h expected %0h (cycle %0d)",
                                     d, p, dt, sb[idx].data, cyc);
                        end
                        sb.delete(idx);
                    end
                end
            end
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_valid dut%0d port%0d: got no valid, expected %0h at cycle %0d",
                         sb[i].dut, sb[i].port, sb[i].data, sb[i].due);
                sb.delete(i);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int bc_a, bc_b, dc_a, dc_b;
        rst = 1'b1; init = 1'b0; init_val = '0; wea = 1'b0; addra = '0; dina = '0;
        rd_en = '0; rd_addr = '0;
        wea_c = 1'b0; addra_c = '0; dina_c = '0; rd_en_c = '0; rd_addr_c = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {busy_a, busy_b, busy_c}, 3'b000);
        check("reset_wr_drop", {wr_drop_a, wr_drop_b, wr_drop_c}, 3'b000);
        check("reset_rd_valid", {rdv_a, rdv_b, rdv_c}, 8'h00);
        check("reset_rd_data_a", rdd_a, 24'h0);
        check("reset_rd_data_c", rdd_c, 16'h0);
        step();
        rst = 1'b0;

        // Write 0x10+a everywhere, then three ports in one cycle
        for (int a = 0; a < 16; a++) begin
            step();
            wea = 1'b1; addra = 4'(a); dina = 8'h10 + 8'(a);
        end
        step();
        wea = 1'b0; rd_en = 3'b111; rd_addr = {4'd15, 4'd3, 4'd3};
        for (int d = 0; d < 2; d++) begin
            push(d, 0, 8'h13); push(d, 1, 8'h13); push(d, 2, 8'h1F);
        end
        step();
        rd_en = '0;
        repeat (3) step();

        // Fill with 0xA5, busy must last exactly 16 cycles
        init = 1'b1; init_val = 8'hA5;
        bc_a = 0; bc_b = 0;
        for (int j = 1; j <= 30; j++) begin
            step();
            init = 1'b0;
            @(negedge clk);
            bc_a += int'(busy_a); bc_b += int'(busy_b);
        end
        check("fill_busy_cycles_a", bc_a, 16);
        check("fill_busy_cycles_b", bc_b, 16);
        for (int a = 0; a < 16; a++) begin
            step();
            rd_en = 3'b010; rd_addr[7:4] = 4'(a);
            push(0, 1, 8'hA5); push(1, 1, 8'hA5);
        end
        step();
        rd_en = '0;
        repeat (3) step();

        // Write during fill is dropped; init during fill is ignored
        init = 1'b1; init_val = 8'hA5;
        bc_a = 0; dc_a = 0; dc_b = 0;
        for (int j = 1; j <= 30; j++) begin
            step();
            init = (j == 6); wea = (j == 3); addra = 4'd7; dina = 8'h3C;
            @(negedge clk);
            bc_a += int'(busy_a); dc_a += int'(wr_drop_a); dc_b += int'(wr_drop_b);
        end
        check("refill_busy_cycles", bc_a, 16);
        check("wr_drop_pulses_a", dc_a, 1);
        check("wr_drop_pulses_b", dc_b, 1);
        step();
        rd_en = 3'b101; rd_addr = {4'd8, 4'd0, 4'd7};
        push(0, 0, 8'hA5); push(1, 0, 8'hA5); push(0, 2, 8'hA5); push(1, 2, 8'hA5);
        step();
        rd_en = '0;
        repeat (3) step();

        // Read-during-write: old data on u_a, new data on u_b
        wea = 1'b1; addra = 4'd5; dina = 8'h11;
        step();
        dina = 8'h22; rd_en = 3'b100; rd_addr = {4'd5, 4'd0, 4'd0};
        push(0, 2, 8'h11); push(1, 2, 8'h22);
        step();
        wea = 1'b0;
        push(0, 2, 8'h22); push(1, 2, 8'h22);
        step();
        rd_en = '0;
        repeat (3) step();

        // Fill 0x00, then reset mid-way through a 0xFF fill after six writes
        init = 1'b1; init_val = 8'h00;
        step();
        init = 1'b0;
        repeat (20) step();
        init = 1'b1; init_val = 8'hFF;
        for (int j = 1; j <= 6; j++) begin
            step();
            init = 1'b0;
            if (j == 6) begin
                rd_en = 3'b001; rd_addr = 12'h000;
            end
        end
        step();
        rd_en = '0;
        rst = 1'b1;
        #1;
        check("midfill_reset_busy", {busy_a, busy_b}, 2'b00);
        check("midfill_reset_valid", {rdv_a, rdv_b}, 6'b0);
        check("midfill_reset_data", rdd_a, 24'h0);
        step();
        rst = 1'b0;
        repeat (3) step();
        for (int a = 0; a < 16; a++) begin
            rd_en = 3'b100; rd_addr[11:8] = 4'(a);
            push(0, 2, (a < 6) ? 8'hFF : 8'h00);
            push(1, 2, (a < 6) ? 8'hFF : 8'h00);
            step();
        end
        rd_en = '0;
        repeat (3) step();

        // Legacy configuration: full sweep, reads trail the writes
        for (int a = 0; a <= 65536; a++) begin
            wea_c   = (a < 65536);
            addra_c = 16'(a);
            dina_c  = pat(a);
            if (a > 0) begin
                rd_en_c   = 2'b11;
                rd_addr_c = {16'(a >> 1), 16'(a - 1)};
                push(2, 0, pat(a - 1));
                push(2, 1, pat(a >> 1));
            end
            step();
        end
        wea_c = 1'b0; rd_en_c = '0;
        repeat (5) step();

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
